// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Produces HS/VS,
//               active-video flag, pixel coordinates and line/frame start
//               strobes on a single clock gated by a pixel-step enable.
//               Sync/active are realigned to a downstream pixel pipeline by
//               a PIPE_DLY-stage delay line that advances only on pixel steps.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iCLK          in   1   system clock, all state on posedge
//   ireset_n      in   1   asynchronous active-low reset
//   iPIX_EN       in   1   pixel-step enable
//   oVGA_HS       out  1   horizontal sync, asserted level = H_POL
//   oVGA_VS       out  1   vertical sync, asserted level = V_POL
//   oVGA_ACTIVE   out  1   active-video flag
//   oVGA_SYNC     out  1   tied high
//   opixel_x      out  CW  horizontal counter
//   opixel_y      out  CW  vertical counter
//   oLINE_START   out  1   one-cycle pulse after each horizontal wrap
//   oFRAME_START  out  1   one-cycle pulse after each frame wrap
//   oframe_count  out  8   frame counter (only with VGA_TIMING_FRAME_CNT_EN)
// Build option
//   VGA_TIMING_FRAME_CNT_EN : when defined, adds oframe_count.
// ============================================================================
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int PIPE_DLY  = 0,
    parameter int CW        = 11
) (
    input  logic          iCLK,
    input  logic          ireset_n,
    input  logic          iPIX_EN,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_ACTIVE,
    output logic          oVGA_SYNC,
    output logic [CW-1:0] opixel_x,
    output logic [CW-1:0] opixel_y,
    output logic          oLINE_START,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [7:0]    oframe_count,
`endif
    output logic          oFRAME_START
);

    localparam int C_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int C_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] C_H_LAST = CW'(C_H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST = CW'(C_V_TOTAL - 1);

    // Decode bounds carry one extra bit so the sync end bound is still
    // representable when a porch is zero and a total equals 2^CW.
    localparam logic [CW:0] C_H_DISP     = (CW+1)'(H_DISPLAY);
    localparam logic [CW:0] C_HS_START   = (CW+1)'(H_DISPLAY + H_FRONT);
    localparam logic [CW:0] C_HS_END     = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW:0] C_V_DISP     = (CW+1)'(V_DISPLAY);
    localparam logic [CW:0] C_VS_START   = (CW+1)'(V_DISPLAY + V_FRONT);
    localparam logic [CW:0] C_VS_END     = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          w_x_wrap;
    logic          w_y_wrap;
    logic [CW:0]   w_x_ext;
    logic [CW:0]   w_y_ext;
    logic [2:0]    w_dec;          // {hs_asserted, vs_asserted, active}

    // Stage 0 is the decode register; stages 1..PIPE_DLY are extra delay.
    // Stored as "asserted" flags so a cleared stage is the idle level.
    logic [2:0]    pipe_q [0:PIPE_DLY];

    // ------------------------------------------------------------------
    // Counter next-state and wrap strobes
    // ------------------------------------------------------------------
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        w_x_wrap      = (x_q == C_H_LAST);
        w_y_wrap      = (y_q == C_V_LAST);
        line_start_d  = iPIX_EN && w_x_wrap;
        frame_start_d = iPIX_EN && w_x_wrap && w_y_wrap;
        if (iPIX_EN) begin
            if (w_x_wrap) begin
                x_d = '0;
                y_d = w_y_wrap ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster decode of the current counter value
    // ------------------------------------------------------------------
    always_comb begin
        w_x_ext  = {1'b0, x_q};
        w_y_ext  = {1'b0, y_q};
        w_dec[2] = (w_x_ext >= C_HS_START) && (w_x_ext < C_HS_END);
        w_dec[1] = (w_y_ext >= C_VS_START) && (w_y_ext < C_VS_END);
        w_dec[0] = (w_x_ext < C_H_DISP) && (w_y_ext < C_V_DISP);
    end

    always_ff @(posedge iCLK or negedge ireset_n) begin
        if (!ireset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            // Pulses are written every cycle, so they fall after one iCLK
            // even while iPIX_EN stays low.
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge iCLK or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                pipe_q[i] <= 3'b000;
            end
        end else if (iPIX_EN) begin
            pipe_q[0] <= w_dec;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Advances on the same edge that raises oFRAME_START.
    always_ff @(posedge iCLK or negedge ireset_n) begin
        if (!ireset_n) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign oframe_count = frame_cnt_q;
`endif

    assign oVGA_HS      = pipe_q[PIPE_DLY][2] ? H_POL : ~H_POL;
    assign oVGA_VS      = pipe_q[PIPE_DLY][1] ? V_POL : ~V_POL;
    assign oVGA_ACTIVE  = pipe_q[PIPE_DLY][0];
    assign oVGA_SYNC    = 1'b1;
    assign opixel_x     = x_q;
    assign opixel_y     = y_q;
    assign oLINE_START  = line_start_q;
    assign oFRAME_START = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen. Two
//               instances on a reduced raster (15 x 8): A with default
//               polarity and no extra delay, B with positive polarity and
//               PIPE_DLY=2. Expected values come from the step count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HD = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VD = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HD + HF + HS + HB;   // 15
    localparam int VT = VD + VF + VS + VB;   // 8
    localparam int FT = HT * VT;             // 120

    logic       clk;
    logic       rst_n;
    logic       pix_en;

    logic       a_hs, a_vs, a_act, a_sync, a_ls, a_fs;
    logic [3:0] a_x, a_y;
    logic       b_hs, b_vs, b_act, b_sync, b_ls, b_fs;
    logic [3:0] b_x, b_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] a_fcnt, b_fcnt;
`endif

    logic [12:0] a_vec, b_vec;
    assign a_vec = {a_x, a_y, a_hs, a_vs, a_act, a_ls, a_fs};
    assign b_vec = {b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs};

    int   n_pass;
    int   n_total;
    int   n;          // pixel steps since reset release
    logic stepped;    // previous edge was a pixel step

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(0), .CW(4)
    ) u_dut_a (
        .iCLK         (clk),
        .ireset_n     (rst_n),
        .iPIX_EN      (pix_en),
        .oVGA_HS      (a_hs),
        .oVGA_VS      (a_vs),
        .oVGA_ACTIVE  (a_act),
        .oVGA_SYNC    (a_sync),
        .opixel_x     (a_x),
        .opixel_y     (a_y),
        .oLINE_START  (a_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .oframe_count (a_fcnt),
`endif
        .oFRAME_START (a_fs)
    );

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(2), .CW(4)
    ) u_dut_b (
        .iCLK         (clk),
        .ireset_n     (rst_n),
        .iPIX_EN      (pix_en),
        .oVGA_HS      (b_hs),
        .oVGA_VS      (b_vs),
        .oVGA_ACTIVE  (b_act),
        .oVGA_SYNC    (b_sync),
        .opixel_x     (b_x),
        .opixel_y     (b_y),
        .oLINE_START  (b_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .oframe_count (b_fcnt),
`endif
        .oFRAME_START (b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {x, y, hs, vs, active, line_start, frame_start} after n steps.
    function automatic logic [12:0] model(input int steps, input int dly,
                                          input logic pol, input logic stp);
        int         m, xm, ym;
        logic [3:0] ex, ey;
        logic       hs_a, vs_a, act, ls, fs;
        ex   = 4'(steps % HT);
        ey   = 4'((steps / HT) % VT);
        hs_a = 1'b0;
        vs_a = 1'b0;
        act  = 1'b0;
        if (steps >= 1 + dly) begin
            m    = steps - 1 - dly;
            xm   = m % HT;
            ym   = (m / HT) % VT;
            act  = (xm < HD) && (ym < VD);
            hs_a = (xm >= HD + HF) && (xm < HD + HF + HS);
            vs_a = (ym >= VD + VF) && (ym < VD + VF + VS);
        end
        ls = stp && (steps > 0) && (steps % HT == 0);
        fs = stp && (steps > 0) && (steps % FT == 0);
        return {ex, ey, (hs_a ? pol : ~pol), (vs_a ? pol : ~pol), act, ls, fs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (step %0d)",
                    tag, obs, exp, n);
    endtask

    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        stepped = en;
        if (en) n++;
    endtask

    task automatic check_both(input string tag);
        chk({tag, "_A"}, 32'(a_vec), 32'(model(n, 0, 1'b0, stepped)));
        chk({tag, "_B"}, 32'(b_vec), 32'(model(n, 2, 1'b1, stepped)));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        n       = 0;
        stepped = 1'b0;
        rst_n   = 1'b0;
        pix_en  = 1'b0;

        // Reset state: counters 0, idle sync levels, no pulses.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_A", 32'(a_vec), 32'({4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("rst_B", 32'(b_vec), 32'({4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk("sync_tied", 32'({a_sync, b_sync}), 32'(2'b11));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_rst", 32'({a_fcnt, b_fcnt}), 32'(16'h0000));
`endif

        // Release; with enable low nothing moves.
        rst_n = 1'b1;
        tick(1'b0);
        check_both("hold0");

        // Free-running over two frame wraps.
        for (int i = 0; i < 260; i++) begin
            tick(1'b1);
            check_both("run");
        end

        // Irregular enable: hold behaviour and single-cycle pulses.
        for (int i = 0; i < 240; i++) begin
            tick((i % 3) != 0);
            check_both("tog");
        end

        // Asynchronous reset mid-line, away from the clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_A", 32'(a_vec), 32'({4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("arst_B", 32'(b_vec), 32'({4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_hold_x", 32'({a_x, b_x}), 32'(8'h00));
        rst_n   = 1'b1;
        n       = 0;
        stepped = 1'b0;

        // Hand-computed HS edges after release: A falls when it shows x=10
        // (after step 11), B rises two steps later (after step 13).
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            check_both("post_rst");
        end
        chk("hs_a_n10", 32'(a_hs), 32'(1'b1));
        chk("hs_b_n10", 32'(b_hs), 32'(1'b0));
        tick(1'b1);
        chk("hs_a_n11", 32'(a_hs), 32'(1'b0));
        chk("hs_b_n11", 32'(b_hs), 32'(1'b0));
        tick(1'b1);
        tick(1'b1);
        chk("hs_a_n13", 32'(a_hs), 32'(1'b0));
        chk("hs_b_n13", 32'(b_hs), 32'(1'b1));
        tick(1'b1);
        chk("hs_a_n14", 32'(a_hs), 32'(1'b1));
        chk("ls_n14", 32'({a_ls, b_ls}), 32'(2'b00));
        tick(1'b1);
        chk("ls_n15", 32'({a_ls, b_ls, a_x, a_y}), 32'({2'b11, 4'd0, 4'd1}));

        // Run past the first frame wrap after the mid-line reset.
        while (n < 2 * FT + 5) begin
            tick(1'b1);
            check_both("frame");
        end

`ifdef VGA_TIMING_FRAME_CNT_EN
        // Frame counter across the 255 -> 0 wrap.
        while (n < 257 * FT) begin
            tick(1'b1);
            if (n % FT == 0) begin
                chk("fcnt_A", 32'(a_fcnt), 32'((n / FT) % 256));
                chk("fcnt_B", 32'(b_fcnt), 32'((n / FT) % 256));
                chk("fcnt_fs", 32'({a_fs, a_ls}), 32'(2'b11));
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
